// File: rtl/init_seq_num_gen.sv
// Per-flow ISN generator: tick clock plus LFSR offset, written to the
// ISN memory and returned to the requesting flow allocator.
module init_seq_num_gen #(
   parameter int width_p = 32,
   parameter int els_p = 16,
   parameter int addr_w = (els_p > 1) ? $clog2(els_p) : 1,
   parameter int tick_div_p = 250,
   parameter logic [width_p-1:0] lfsr_seed_p = width_p'(32'h1),
   parameter logic [width_p-1:0] lfsr_taps_p = width_p'(32'h80200003)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               new_flow_val,
   input  logic [addr_w-1:0]  new_flow_id,
   output logic               new_flow_rdy,
   output logic               isn_wr_req_val,
   output logic [addr_w-1:0]  isn_wr_req_addr,
   output logic [width_p-1:0] isn_wr_num,
   input  logic               isn_wr_req_rdy,
   output logic               isn_notify_val,
   output logic [addr_w-1:0]  isn_notify_id,
   output logic [width_p-1:0] isn_notify_num,
   input  logic               isn_notify_rdy
);

   localparam int div_w = (tick_div_p > 1) ? $clog2(tick_div_p) : 1;
   localparam logic [div_w-1:0] div_last = div_w'(tick_div_p - 1);
   // An all-zero seed would lock the LFSR at zero forever
   localparam logic [width_p-1:0] lfsr_init =
      (lfsr_seed_p == '0) ? width_p'(1) : lfsr_seed_p;

   typedef enum logic {IDLE, BUSY} state_e;

   state_e             state, state_n;
   logic [div_w-1:0]   div_cnt, div_n;
   logic [width_p-1:0] tick_cnt, tick_n;
   logic [width_p-1:0] lfsr, lfsr_n;
   logic [addr_w-1:0]  id_q, id_n;
   logic [width_p-1:0] num_q, num_n;
   logic               wr_val, wr_val_n;
   logic               nt_val, nt_val_n;
   logic               wr_done, nt_done;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         div_cnt  <= '0;
         tick_cnt <= '0;
         lfsr     <= lfsr_init;
         id_q     <= '0;
         num_q    <= '0;
         wr_val   <= 1'b0;
         nt_val   <= 1'b0;
      end else begin
         state    <= state_n;
         div_cnt  <= div_n;
         tick_cnt <= tick_n;
         lfsr     <= lfsr_n;
         id_q     <= id_n;
         num_q    <= num_n;
         wr_val   <= wr_val_n;
         nt_val   <= nt_val_n;
      end
   end

   always_comb begin
      state_n  = state;
      id_n     = id_q;
      num_n    = num_q;
      wr_val_n = wr_val;
      nt_val_n = nt_val;
      div_n    = div_cnt + 1'b1;
      tick_n   = tick_cnt;
      if (div_cnt == div_last) begin
         div_n  = '0;
         tick_n = tick_cnt + 1'b1;
      end
      lfsr_n = lfsr >> 1;
      if (lfsr[0])
         lfsr_n = (lfsr >> 1) ^ lfsr_taps_p;
      wr_done = !wr_val || isn_wr_req_rdy;
      nt_done = !nt_val || isn_notify_rdy;
      unique case (state)
         IDLE: begin
            if (new_flow_val) begin
               id_n     = new_flow_id;
               num_n    = tick_cnt + lfsr;
               wr_val_n = 1'b1;
               nt_val_n = 1'b1;
               state_n  = BUSY;
            end
         end
         BUSY: begin
            if (isn_wr_req_rdy)
               wr_val_n = 1'b0;
            if (isn_notify_rdy)
               nt_val_n = 1'b0;
            if (wr_done && nt_done)
               state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign new_flow_rdy    = (state == IDLE);
   assign isn_wr_req_val  = wr_val;
   assign isn_wr_req_addr = id_q;
   assign isn_wr_num      = num_q;
   assign isn_notify_val  = nt_val;
   assign isn_notify_id   = id_q;
   assign isn_notify_num  = num_q;

endmodule

// File: tb/tb_init_seq_num_gen.sv
// Bench for init_seq_num_gen: a 32-bit instance and an 8-bit instance
// (fast tick, zero seed) compared every cycle against a behavioural model.
module tb_init_seq_num_gen;

   localparam logic [31:0] WM   [2] = '{32'hFFFF_FFFF, 32'h0000_00FF};
   localparam logic [31:0] TAPS [2] = '{32'h8020_0003, 32'h0000_00B8};
   localparam logic [31:0] AM   [2] = '{32'h0000_000F, 32'h0000_0003};
   localparam int          DIV  [2] = '{4, 1};

   logic clk = 1'b0;
   logic rst;
   logic        val  [2];
   logic [31:0] fid  [2];
   logic        wrdy [2];
   logic        nrdy [2];

   logic frdy0, frdy1, wv0, wv1, nv0, nv1;
   logic [3:0]  wa0, ni0;
   logic [1:0]  wa1, ni1;
   logic [31:0] wn0, nn0;
   logic [7:0]  wn1, nn1;

   int n_chk = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   init_seq_num_gen #(
      .width_p(32), .els_p(16), .tick_div_p(4),
      .lfsr_seed_p(32'h1), .lfsr_taps_p(32'h8020_0003)
   ) u0 (
      .clk(clk), .rst(rst),
      .new_flow_val(val[0]), .new_flow_id(fid[0][3:0]),
      .new_flow_rdy(frdy0),
      .isn_wr_req_val(wv0), .isn_wr_req_addr(wa0),
      .isn_wr_num(wn0), .isn_wr_req_rdy(wrdy[0]),
      .isn_notify_val(nv0), .isn_notify_id(ni0),
      .isn_notify_num(nn0), .isn_notify_rdy(nrdy[0])
   );

   init_seq_num_gen #(
      .width_p(8), .els_p(4), .tick_div_p(1),
      .lfsr_seed_p(8'h0), .lfsr_taps_p(8'hB8)
   ) u1 (
      .clk(clk), .rst(rst),
      .new_flow_val(val[1]), .new_flow_id(fid[1][1:0]),
      .new_flow_rdy(frdy1),
      .isn_wr_req_val(wv1), .isn_wr_req_addr(wa1),
      .isn_wr_num(wn1), .isn_wr_req_rdy(wrdy[1]),
      .isn_notify_val(nv1), .isn_notify_id(ni1),
      .isn_notify_num(nn1), .isn_notify_rdy(nrdy[1])
   );

   task automatic chk(input string nm, input int inst,
                      input longint unsigned act,
                      input longint unsigned exp);
      n_chk++;
      if (act == exp)
         n_pass++;
      else
         $display("FAIL %s[%0d]: got %0h expected %0h", nm, inst, act, exp);
   endtask

   // Behavioural model state
   bit             mvalid = 1'b0;
   bit             busy [2];
   bit             wp   [2];
   bit             np   [2];
   bit             rseen[2];
   longint unsigned cyc [2];
   logic [31:0]    lf   [2];
   logic [31:0]    e_id [2];
   logic [31:0]    e_num[2];
   int             acc  [2] = '{0, 0};

   always @(negedge clk) begin
      logic        o_frdy [2];
      logic        o_wv   [2];
      logic        o_nv   [2];
      logic [31:0] o_wa   [2];
      logic [31:0] o_ni   [2];
      logic [31:0] o_wn   [2];
      logic [31:0] o_nn   [2];
      logic [31:0] isn;
      bit wd, nd;
      o_frdy = '{frdy0, frdy1};
      o_wv   = '{wv0, wv1};
      o_nv   = '{nv0, nv1};
      o_wa   = '{32'(wa0), 32'(wa1)};
      o_ni   = '{32'(ni0), 32'(ni1)};
      o_wn   = '{wn0, 32'(wn1)};
      o_nn   = '{nn0, 32'(nn1)};
      for (int i = 0; i < 2; i++) begin
         if (mvalid) begin
            if (rseen[i]) begin
               chk("rst_wr_addr", i, o_wa[i], 0);
               chk("rst_wr_num", i, o_wn[i], 0);
               chk("rst_nt_id", i, o_ni[i], 0);
               chk("rst_nt_num", i, o_nn[i], 0);
            end
            chk("new_flow_rdy", i, o_frdy[i], !busy[i]);
            chk("wr_val", i, o_wv[i], wp[i]);
            chk("nt_val", i, o_nv[i], np[i]);
            if (wp[i]) begin
               chk("wr_addr", i, o_wa[i], e_id[i]);
               chk("wr_num", i, o_wn[i], e_num[i]);
            end
            if (np[i]) begin
               chk("nt_id", i, o_ni[i], e_id[i]);
               chk("nt_num", i, o_nn[i], e_num[i]);
            end
         end
         if (rst) begin
            busy[i] = 0; wp[i] = 0; np[i] = 0;
            cyc[i] = 0; lf[i] = 32'h1; rseen[i] = 1;
         end else begin
            rseen[i] = 0;
            if (!busy[i]) begin
               if (val[i]) begin
                  isn = 32'((cyc[i] / DIV[i]) + lf[i]) & WM[i];
                  e_id[i] = fid[i] & AM[i];
                  e_num[i] = isn;
                  wp[i] = 1; np[i] = 1; busy[i] = 1;
                  acc[i]++;
               end
            end else begin
               wd = !wp[i] || wrdy[i];
               nd = !np[i] || nrdy[i];
               if (wp[i] && wrdy[i]) wp[i] = 0;
               if (np[i] && nrdy[i]) np[i] = 0;
               if (wd && nd) busy[i] = 0;
            end
            cyc[i]++;
            if (lf[i][0])
               lf[i] = ((lf[i] >> 1) ^ TAPS[i]) & WM[i];
            else
               lf[i] = lf[i] >> 1;
         end
      end
      if (rst)
         mvalid = 1'b1;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int a0;
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         val[i] = 0; fid[i] = 0; wrdy[i] = 1; nrdy[i] = 1;
      end
      step(3);
      // Request in the very first cycle after reset
      rst = 1'b0; val[0] = 1; fid[0] = 5;
      step(1);
      val[0] = 0;
      chk("t1_wr_val", 0, wv0, 1);
      chk("t1_addr", 0, wa0, 5);
      chk("t1_num", 0, wn0, 1);
      chk("t1_nt_id", 0, ni0, 5);
      chk("t1_nt_num", 0, nn0, 1);
      chk("t1_rdy_busy", 0, frdy0, 0);
      step(1);
      chk("t1_rdy_back", 0, frdy0, 1);
      // Accept after two LFSR steps: 1 -> 80200003 -> C0300002
      val[0] = 1; fid[0] = 3;
      step(1);
      val[0] = 0;
      chk("t1_lfsr2", 0, wn0, 32'hC030_0002);
      step(1);
      // Write channel back-pressured for three cycles
      wrdy[0] = 0; val[0] = 1; fid[0] = 7;
      step(1);
      val[0] = 0;
      step(3);
      chk("t2_nt_done", 0, nv0, 0);
      chk("t2_wr_held", 0, wv0, 1);
      chk("t2_rdy_low", 0, frdy0, 0);
      wrdy[0] = 1;
      step(1);
      chk("t2_idle", 0, frdy0, 1);
      // Tick counters: 40 and 256 idle cycles
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      step(40);
      chk("t3_tick10", 0, u0.tick_cnt, 10);
      step(216);
      chk("t4_tick_wrap", 1, u1.tick_cnt, 0);
      chk("t3_tick64", 0, u0.tick_cnt, 64);
      val[0] = 1; fid[0] = 9; val[1] = 1; fid[1] = 2;
      step(1);
      val[0] = 0; val[1] = 0;
      step(1);
      // Back-to-back requests: one accept per two cycles
      a0 = acc[0];
      val[0] = 1;
      for (int k = 0; k < 20; k++) begin
         fid[0] = $urandom;
         step(1);
      end
      val[0] = 0;
      chk("t5_accepts", 0, acc[0] - a0, 10);
      step(2);
      // Reset while busy with both channels stalled
      wrdy[0] = 0; nrdy[0] = 0; val[0] = 1; fid[0] = 11;
      step(1);
      val[0] = 0;
      step(1);
      rst = 1'b1;
      step(1);
      chk("t6_wr_val", 0, wv0, 0);
      chk("t6_nt_val", 0, nv0, 0);
      chk("t6_rdy", 0, frdy0, 1);
      rst = 1'b0;
      // Randomised traffic on both instances
      for (int k = 0; k < 3000; k++) begin
         for (int i = 0; i < 2; i++) begin
            val[i]  = ($urandom % 2) == 0;
            fid[i]  = $urandom;
            wrdy[i] = ($urandom % 4) != 0;
            nrdy[i] = ($urandom % 4) != 0;
         end
         rst = ($urandom % 500) == 0;
         step(1);
      end
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         val[i] = 0; wrdy[i] = 1; nrdy[i] = 1;
      end
      step(4);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
